dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port byte-addressed data memory between two requesters:
//   the core load/store port (C) and the program/debug loader port (L).
//   Each accepted request is sequenced through one memory access cycle, then returned as a response.
//   Alignment and range are checked before the access, so a bad request never issues a memory strobe.
//   Sits between the core/loader and the data memory's MemRead/MemWrite/funct3/address/write_data/read_data pins.
// PARAMETERS
//   DEPTH_BYTES  1024  memory size in bytes; an access whose highest byte address >= DEPTH_BYTES is an error
// PORTS
//   clk         in   1   single clock, all state updates on rising edge
//   rst         in   1   asynchronous, active-high reset
//   c_req       in   1   core request; held with its fields stable until c_gnt
//   c_we        in   1   1=store, 0=load
//   c_funct3    in   3   RV32 width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   c_addr      in   32  byte address
//   c_wdata     in   32  store data
//   c_gnt       out  1   1-cycle pulse: core request accepted this cycle
//   c_rvalid    out  1   1-cycle pulse: core response valid
//   c_rdata     out  32  load data; 0 for stores and errors
//   c_err       out  1   qualified by c_rvalid: misaligned, illegal funct3 or out of range
//   l_req/l_we/l_funct3/l_addr/l_wdata   in    as the c_* inputs, loader port
//   l_gnt/l_rvalid/l_rdata/l_err         out   as the c_* outputs, loader port
//   MemRead     out  1   memory read strobe
//   MemWrite    out  1   memory write strobe; memory commits on the clk edge ending the cycle
//   funct3      out  3   width code to memory
//   address     out  32  byte address to memory
//   write_data  out  32  store data to memory
//   read_data   in   32  combinational read data from memory
// BEHAVIOUR
//   Reset: state=IDLE, last=L, all outputs 0, command registers 0.
//   FSM: IDLE -> ACCESS -> RESP -> IDLE. Sustained throughput is 1 request per 3 cycles.
//   IDLE: if any req is high, select owner; pulse owner's gnt combinationally in this cycle.
//     On the edge: latch we/funct3/addr/wdata, owner and err; last<=owner; go to ACCESS.
//     No req: stay in IDLE.
//   Arbitration: a lone requester wins. If both request, the owner is the port != last
//     (round-robin); after reset C wins the first tie. The loser keeps req high and is served next.
//   ACCESS: address/funct3/write_data driven from latches.
//     MemRead = ~we & ~err; MemWrite = we & ~err.
//     read_data is captured into the response register at the ending edge; go to RESP.
//   RESP: owner's rvalid=1 for exactly one cycle with rdata/err; non-owner rvalid=0; go to IDLE.
//     rdata = captured load data, or 0 if we or err.
//   MemRead and MemWrite are 0 in IDLE and RESP; address/funct3/write_data hold their latched values.
//   err (computed at accept from the selected fields):
//     load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010};
//     halfword with addr[0]!=0; word with addr[1:0]!=0;
//     addr + size-1 >= DEPTH_BYTES (use 33-bit compare, no wrap).
//   gnt is never asserted outside IDLE. A request raised during ACCESS/RESP waits.
//   Async reset mid-ACCESS drops MemWrite immediately; the interrupted request gets no response.
// TESTING
//   C LW 0x10, L idle -> c_gnt cycle0; MemRead=1 cycle1; c_rvalid=1 cycle2 with c_rdata = word at 0x10.
//   C SW 0x20 0xDEADBEEF, then C LW 0x20 -> MemWrite=1 for one cycle; load returns 0xDEADBEEF, err=0.
//   C and L both request from reset -> C granted first, L 3 cycles later; repeat tie -> grants alternate.
//   C SH addr 0x21 / L SW addr 0x3FE / C funct3=011 -> err=1, rdata=0, MemRead=MemWrite=0 throughout.
//   L SB 0x3FF 0xA5 then C LBU 0x3FF -> MemWrite=1, err=0; load returns 0x000000A5. Same LB -> 0xFFFFFFA5.
//   rst pulsed during ACCESS of a store -> MemWrite falls with rst; no rvalid; next request starts from IDLE.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core port, the loader port, the arbiter and the data memory.
// Each requester holds req with stable fields until the arbiter answers with a 1-cycle gnt.
interface dmem_arbiter_if;
  // Core load/store port
  logic        c_req;
  logic        c_we;
  logic [2:0]  c_funct3;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_gnt;
  logic        c_rvalid;
  logic [31:0] c_rdata;
  logic        c_err;

  // Loader port
  logic        l_req;
  logic        l_we;
  logic [2:0]  l_funct3;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic        l_err;

  // Memory pins
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport slave (
    input  c_req, c_we, c_funct3, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, c_err,
    input  l_req, l_we, l_funct3, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output MemRead, MemWrite, funct3, address, write_data,
    input  read_data
  );

  modport master (
    output c_req, c_we, c_funct3, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, c_err,
    output l_req, l_we, l_funct3, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  MemRead, MemWrite, funct3, address, write_data,
    output read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (C) and loader (L).
// Each accepted request runs IDLE -> ACCESS -> RESP; bad requests never raise a memory strobe.
module dmem_arbiter #(
  parameter int unsigned DEPTH_BYTES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  dmem_arbiter_if.slave    bus,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_L = 1'b1;

  state_t      state_q;
  logic        last_q;
  logic        owner_q;
  logic        we_q;
  logic        err_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        c_rvalid_q;
  logic        c_err_q;
  logic [31:0] c_rdata_q;
  logic        l_rvalid_q;
  logic        l_err_q;
  logic [31:0] l_rdata_q;

  logic        any_req;
  logic        owner_d;
  logic        we_d;
  logic [2:0]  funct3_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic        err_d;
  logic [31:0] resp_data;

  // span = size-1; its bits double as the alignment mask for the low address bits.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr);
    logic        legal;
    logic [1:0]  span;
    logic        misalign;
    logic [32:0] top;
    legal = 1'b0;
    span  = 2'd0;
    case (f3)
      3'b000: legal = 1'b1;
      3'b001: begin legal = 1'b1; span = 2'd1; end
      3'b010: begin legal = 1'b1; span = 2'd3; end
      3'b100: legal = ~we;
      3'b101: begin legal = ~we; span = 2'd1; end
      default: legal = 1'b0;
    endcase
    misalign = |(addr[1:0] & span);
    top      = {1'b0, addr} + {31'd0, span};
    return ~legal | misalign | (top >= 33'(DEPTH_BYTES));
  endfunction

  // L wins alone, or on a tie when C was served last.
  assign any_req  = bus.c_req | bus.l_req;
  assign owner_d  = bus.l_req & (~bus.c_req | (last_q == OWN_C));
  assign we_d     = owner_d ? bus.l_we     : bus.c_we;
  assign funct3_d = owner_d ? bus.l_funct3 : bus.c_funct3;
  assign addr_d   = owner_d ? bus.l_addr   : bus.c_addr;
  assign wdata_d  = owner_d ? bus.l_wdata  : bus.c_wdata;
  assign err_d    = access_err(we_d, funct3_d, addr_d);

  assign resp_data = (we_q | err_q) ? 32'd0 : bus.read_data;

  assign bus.c_gnt = (state_q == S_IDLE) & bus.c_req & ~owner_d;
  assign bus.l_gnt = (state_q == S_IDLE) & owner_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= OWN_L;
      owner_q     <= OWN_C;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      c_rvalid_q  <= 1'b0;
      c_err_q     <= 1'b0;
      c_rdata_q   <= 32'd0;
      l_rvalid_q  <= 1'b0;
      l_err_q     <= 1'b0;
      l_rdata_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q     <= owner_d;
            last_q      <= owner_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            mem_read_q  <= ~we_d & ~err_d;
            mem_write_q <= we_d & ~err_d;
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (owner_q == OWN_L) begin
            l_rvalid_q <= 1'b1;
            l_rdata_q  <= resp_data;
            l_err_q    <= err_q;
          end else begin
            c_rvalid_q <= 1'b1;
            c_rdata_q  <= resp_data;
            c_err_q    <= err_q;
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          c_rvalid_q <= 1'b0;
          c_err_q    <= 1'b0;
          c_rdata_q  <= 32'd0;
          l_rvalid_q <= 1'b0;
          l_err_q    <= 1'b0;
          l_rdata_q  <= 32'd0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.c_rvalid   = c_rvalid_q;
  assign bus.c_rdata    = c_rdata_q;
  assign bus.c_err      = c_err_q;
  assign bus.l_rvalid   = l_rvalid_q;
  assign bus.l_rdata    = l_rdata_q;
  assign bus.l_err      = l_err_q;
  assign bus.MemRead    = mem_read_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.funct3     = funct3_q;
  assign bus.address    = addr_q;
  assign bus.write_data = wdata_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory behind the DUT plus a transaction-level
// reference model (round-robin order, 3-cycle slots, error rules, byte-array contents).
module tb_dmem_arbiter;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  logic       mem_load;
  logic [31:0] mem_word;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH_BYTES(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  logic [7:0] seed_mem [DEPTH];
  logic [7:0] dut_mem  [DEPTH];
  logic [7:0] ref_mem  [DEPTH];

  int checks = 0;
  int errors = 0;

  // Reference model state
  txn_t        cq[$];
  txn_t        lq[$];
  logic [32:0] exp_c_q[$];
  logic [32:0] exp_l_q[$];
  int          m_phase;
  bit          m_last;
  bit          m_owner;
  bit          m_we;
  bit          m_err;
  logic [2:0]  m_f3;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          c_first;
  int          l_first;

  // ---------------- data memory seen by the DUT ----------------
  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  always_comb begin
    mem_word = '0;
    for (int i = 0; i < 4; i++)
      if (({1'b0, bus.address} + 33'(i)) < 33'(DEPTH))
        mem_word[8*i +: 8] = dut_mem[10'(bus.address + 32'(i))];
    bus.read_data = ext(bus.funct3, mem_word);
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < DEPTH; i++) dut_mem[i] <= seed_mem[i];
    end else if (bus.MemWrite) begin
      for (int i = 0; i < 4; i++)
        if (i < size_of(bus.funct3) && (({1'b0, bus.address} + 33'(i)) < 33'(DEPTH)))
          dut_mem[10'(bus.address + 32'(i))] <= bus.write_data[8*i +: 8];
    end
  end

  // ---------------- reference model ----------------
  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    int sz;
    longint unsigned last_byte;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    sz = size_of(f3);
    if ((addr % 32'(sz)) != 0) return 1'b1;
    last_byte = {32'd0, addr} + 64'(sz - 1);
    return last_byte >= 64'(DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    longint v;
    int sz;
    sz = size_of(f3);
    v  = 0;
    for (int i = 0; i < sz; i++)
      v += longint'(ref_mem[10'(addr + 32'(i))]) << (8 * i);
    if (f3[2] == 1'b0 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
    for (int i = 0; i < size_of(f3); i++)
      ref_mem[10'(addr + 32'(i))] = d[8*i +: 8];
  endtask

  function automatic txn_t mk(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.f3 = f3; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int k;
    logic [2:0] ld_codes [5];
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    t.we    = 1'($urandom_range(0, 1));
    t.wdata = $urandom;
    k = $urandom_range(0, 9);
    if (k < 8) t.f3 = t.we ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
    else       t.f3 = 3'($urandom_range(0, 7));
    k = $urandom_range(0, 9);
    if (k < 6)       t.addr = 32'($urandom_range(0, 63)) & ~32'(size_of(t.f3) - 1);
    else if (k < 8)  t.addr = 32'(1016 + $urandom_range(0, 7));
    else if (k == 8) t.addr = 32'($urandom_range(0, 63));
    else             t.addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    return t;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_ports(input int c_wait, input int l_wait);
    txn_t t;
    bus.c_req = (cq.size() > 0) && (c_wait == 0);
    t = (cq.size() > 0) ? cq[0] : '0;
    bus.c_we = t.we; bus.c_funct3 = t.f3; bus.c_addr = t.addr; bus.c_wdata = t.wdata;
    bus.l_req = (lq.size() > 0) && (l_wait == 0);
    t = (lq.size() > 0) ? lq[0] : '0;
    bus.l_we = t.we; bus.l_funct3 = t.f3; bus.l_addr = t.addr; bus.l_wdata = t.wdata;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = 1'b1;
    exp_c_q.delete();
    exp_l_q.delete();
  endtask

  task automatic do_reset(input bit load_mem);
    bus.c_req = 1'b0;
    bus.l_req = 1'b0;
    rst = 1'b1;
    mem_load = load_mem;
    @(posedge clk); #1;
    mem_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    if (load_mem) ref_mem = seed_mem;
    model_reset();
  endtask

  // Runs cq/lq to completion, checking every cycle against the model.
  task automatic run_engine(input int budget, input bit rnd_gap);
    int          cyc;
    int          c_wait;
    int          l_wait;
    bit          exp_cg;
    bit          exp_lg;
    logic [32:0] e;
    txn_t        t;
    cyc = 0; c_wait = 0; l_wait = 0; c_first = -1; l_first = -1;
    @(posedge clk); #1;
    drive_ports(c_wait, l_wait);
    while ((cq.size() != 0 || lq.size() != 0 || m_phase != 0) && cyc < budget) begin
      @(negedge clk);
      exp_cg = 1'b0;
      exp_lg = 1'b0;
      if (m_phase == 0) begin
        if (bus.c_req && bus.l_req) begin
          if (m_last) exp_cg = 1'b1; else exp_lg = 1'b1;
        end else if (bus.c_req) exp_cg = 1'b1;
        else if (bus.l_req) exp_lg = 1'b1;
      end
      checks++;
      if ({bus.c_gnt, bus.l_gnt} !== {exp_cg, exp_lg}) begin
        errors++;
        $display("FAIL grant cyc=%0d: got c/l=%b%b expected %b%b", cyc, bus.c_gnt, bus.l_gnt, exp_cg, exp_lg);
      end
      checks++;
      if (m_phase == 1) begin
        if ({bus.MemRead, bus.MemWrite} !== {~m_we & ~m_err, m_we & ~m_err}) begin
          errors++;
          $display("FAIL access_strobes cyc=%0d: got rd/wr=%b%b expected %b%b", cyc,
                   bus.MemRead, bus.MemWrite, ~m_we & ~m_err, m_we & ~m_err);
        end
        checks++;
        if ({bus.address, bus.funct3, bus.write_data} !== {m_addr, m_f3, m_wdata}) begin
          errors++;
          $display("FAIL access_cmd cyc=%0d: got %h/%h/%h expected %h/%h/%h", cyc,
                   bus.address, bus.funct3, bus.write_data, m_addr, m_f3, m_wdata);
        end
      end else if ({bus.MemRead, bus.MemWrite} !== 2'b00) begin
        errors++;
        $display("FAIL idle_strobes cyc=%0d: got rd/wr=%b%b expected 00", cyc, bus.MemRead, bus.MemWrite);
      end
      checks++;
      if (m_phase == 2) begin
        e = m_owner ? exp_l_q.pop_front() : exp_c_q.pop_front();
        if (m_owner) begin
          if ({bus.l_rvalid, bus.c_rvalid, bus.l_err, bus.l_rdata} !== {2'b10, e}) begin
            errors++;
            $display("FAIL l_response cyc=%0d: got v=%b cv=%b err=%b data=%h expected v=1 cv=0 err=%b data=%h",
                     cyc, bus.l_rvalid, bus.c_rvalid, bus.l_err, bus.l_rdata, e[32], e[31:0]);
          end
        end else begin
          if ({bus.c_rvalid, bus.l_rvalid, bus.c_err, bus.c_rdata} !== {2'b10, e}) begin
            errors++;
            $display("FAIL c_response cyc=%0d: got v=%b lv=%b err=%b data=%h expected v=1 lv=0 err=%b data=%h",
                     cyc, bus.c_rvalid, bus.l_rvalid, bus.c_err, bus.c_rdata, e[32], e[31:0]);
          end
        end
      end else if ({bus.c_rvalid, bus.l_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL spurious_rvalid cyc=%0d: got c/l=%b%b expected 00", cyc, bus.c_rvalid, bus.l_rvalid);
      end
      // advance the model by one cycle
      if (m_phase == 0 && (exp_cg || exp_lg)) begin
        t       = exp_cg ? cq[0] : lq[0];
        m_owner = exp_lg;
        m_last  = exp_lg;
        m_we    = t.we;
        m_f3    = t.f3;
        m_addr  = t.addr;
        m_wdata = t.wdata;
        m_err   = model_err(t.we, t.f3, t.addr);
        e = {m_err, (m_we || m_err) ? 32'd0 : model_load(t.f3, t.addr)};
        if (m_we && !m_err) model_store(t.f3, t.addr, t.wdata);
        if (exp_lg) exp_l_q.push_back(e); else exp_c_q.push_back(e);
        if (exp_cg && c_first < 0) c_first = cyc;
        if (exp_lg && l_first < 0) l_first = cyc;
        m_phase = 1;
      end else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2) m_phase = 0;
      @(posedge clk); #1;
      if (exp_cg) begin
        void'(cq.pop_front());
        c_wait = rnd_gap ? $urandom_range(0, 3) : 0;
      end else if (c_wait > 0) c_wait--;
      if (exp_lg) begin
        void'(lq.pop_front());
        l_wait = rnd_gap ? $urandom_range(0, 3) : 0;
      end else if (l_wait > 0) l_wait--;
      drive_ports(c_wait, l_wait);
      cyc++;
    end
    if (cq.size() != 0 || lq.size() != 0 || m_phase != 0) begin
      checks++;
      errors++;
      $display("FAIL engine_timeout: got %0d/%0d txns pending after %0d cycles expected 0", cq.size(), lq.size(), cyc);
    end
    cq.delete();
    lq.delete();
    bus.c_req = 1'b0;
    bus.l_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.c_gnt, bus.l_gnt, bus.c_rvalid, bus.l_rvalid, bus.c_err, bus.l_err,
         bus.MemRead, bus.MemWrite} !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000", {bus.c_gnt, bus.l_gnt, bus.c_rvalid,
               bus.l_rvalid, bus.c_err, bus.l_err, bus.MemRead, bus.MemWrite});
    end
    checks++;
    if ({bus.c_rdata, bus.l_rdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h %h expected 0", bus.c_rdata, bus.l_rdata);
    end
    checks++;
    if ({bus.address, bus.funct3, bus.write_data} !== 67'd0) begin
      errors++;
      $display("FAIL reset_cmd: got %h %h %h expected 0", bus.address, bus.funct3, bus.write_data);
    end
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({dbg_state, bus.c_gnt, bus.l_gnt, bus.MemRead, bus.MemWrite} !== 6'd0) begin
        errors++;
        $display("FAIL idle_hold: got state=%0d gnt=%b%b strobes=%b%b expected all 0", dbg_state,
                 bus.c_gnt, bus.l_gnt, bus.MemRead, bus.MemWrite);
      end
    end
  endtask

  task automatic test_single_load();
    cq.push_back(mk(1'b0, 3'b010, 32'h10, 32'd0));
    run_engine(20, 1'b0);
    checks++;
    if (c_first !== 0) begin
      errors++;
      $display("FAIL single_load_latency: got grant cycle %0d expected 0", c_first);
    end
  endtask

  task automatic test_store_load();
    cq.push_back(mk(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF));
    cq.push_back(mk(1'b0, 3'b010, 32'h20, 32'd0));
    run_engine(30, 1'b0);
  endtask

  task automatic test_tie();
    do_reset(1'b0);
    cq.push_back(mk(1'b0, 3'b010, 32'h40, 32'd0));
    cq.push_back(mk(1'b0, 3'b010, 32'h44, 32'd0));
    lq.push_back(mk(1'b0, 3'b010, 32'h80, 32'd0));
    lq.push_back(mk(1'b0, 3'b010, 32'h84, 32'd0));
    run_engine(40, 1'b0);
    checks++;
    if (c_first !== 0 || l_first !== 3) begin
      errors++;
      $display("FAIL tie_order: got first grants C@%0d L@%0d expected C@0 L@3", c_first, l_first);
    end
  endtask

  task automatic test_errors();
    cq.push_back(mk(1'b1, 3'b001, 32'h21, 32'h1234_5678));
    cq.push_back(mk(1'b0, 3'b011, 32'h30, 32'd0));
    lq.push_back(mk(1'b1, 3'b010, 32'h3FE, 32'hCAFE_F00D));
    lq.push_back(mk(1'b0, 3'b001, 32'hFFFF_FFFE, 32'd0));
    lq.push_back(mk(1'b0, 3'b010, 32'h3FC, 32'd0));
    run_engine(60, 1'b0);
  endtask

  task automatic test_byte_ext();
    lq.push_back(mk(1'b1, 3'b000, 32'h3FF, 32'h0000_00A5));
    run_engine(20, 1'b0);
    cq.push_back(mk(1'b0, 3'b100, 32'h3FF, 32'd0));
    cq.push_back(mk(1'b0, 3'b000, 32'h3FF, 32'd0));
    run_engine(30, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      cq.push_back(rand_txn());
      lq.push_back(rand_txn());
    end
    run_engine(2000, 1'b1);
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] old_word;
    for (int i = 0; i < 4; i++) old_word[8*i +: 8] = ref_mem[10'(32'h100 + 32'(i))];
    @(posedge clk); #1;
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_funct3 = 3'b010;
    bus.c_addr = 32'h100; bus.c_wdata = ~old_word;
    @(negedge clk);
    checks++;
    if (bus.c_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_store_gnt: got %b expected 1", bus.c_gnt);
    end
    @(posedge clk); #1;
    bus.c_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL rst_store_write: got %b expected 1", bus.MemWrite);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.MemWrite, bus.MemRead, dbg_state} !== 4'd0) begin
      errors++;
      $display("FAIL rst_drop_write: got wr=%b rd=%b state=%0d expected 0", bus.MemWrite, bus.MemRead, dbg_state);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.c_rvalid, bus.l_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL rst_no_response: got c/l=%b%b expected 00", bus.c_rvalid, bus.l_rvalid);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_mem[10'(32'h100 + 32'(i))] !== old_word[8*i +: 8]) begin
        errors++;
        $display("FAIL rst_no_commit byte %0d: got %h expected %h", i,
                 dut_mem[10'(32'h100 + 32'(i))], old_word[8*i +: 8]);
      end
    end
    cq.push_back(mk(1'b0, 3'b010, 32'h100, 32'd0));
    lq.push_back(mk(1'b0, 3'b010, 32'h104, 32'd0));
    run_engine(30, 1'b0);
    checks++;
    if (c_first !== 0 || l_first !== 3) begin
      errors++;
      $display("FAIL rst_restart_order: got C@%0d L@%0d expected C@0 L@3", c_first, l_first);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_load = 1'b0;
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_funct3 = 3'd0; bus.c_addr = 32'd0; bus.c_wdata = 32'd0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_funct3 = 3'd0; bus.l_addr = 32'd0; bus.l_wdata = 32'd0;
    for (int i = 0; i < DEPTH; i++) seed_mem[i] = 8'($urandom);
    model_reset();
    test_reset();
    test_single_load();
    test_store_load();
    test_tie();
    test_errors();
    test_byte_ext();
    test_random();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
